// File: rtl/multi_floor_lift.sv
// Multi-floor lift controller: latches calls, serves them with direction preference,
// dwells with the door open at each stop, and latches a fault on switch errors or stalls.
module multi_floor_lift #(
    parameter int N_FLOORS     = 4,
    parameter int DWELL_CYCLES = 4000000,
    parameter int MOVE_TIMEOUT = 40000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call,
    input  logic [N_FLOORS-1:0] fc,
    output logic                motor_up,
    output logic                motor_down,
    output logic [N_FLOORS-1:0] req_lamp,
    output logic                door_open,
    output logic                fault,
    output logic                enable,
    output logic [6:0]          Display
);
    localparam int FW      = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
    localparam int CNT_MAX = (DWELL_CYCLES > MOVE_TIMEOUT) ? DWELL_CYCLES : MOVE_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] MOVE_LAST  = CW'(MOVE_TIMEOUT - 1);
    localparam logic [FW-1:0] FLOOR_TOP  = FW'(N_FLOORS - 1);
    localparam logic [6:0]    SEG_ERR    = 7'b1111001;

    typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DWELL, S_FAULT} state_t;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    state_t                r_state;
    dir_t                  r_last_dir;
    logic [FW-1:0]         r_cur_floor;
    logic [N_FLOORS-1:0]   r_req;
    logic [CW-1:0]         r_cnt;

    state_t                w_state_nx;
    dir_t                  w_dir_nx;
    logic [FW-1:0]         w_floor_nx;
    logic [N_FLOORS-1:0]   w_req_nx;
    logic [CW-1:0]         w_cnt_nx;
    logic [FW-1:0]         w_up_idx;
    logic [FW-1:0]         w_dn_idx;
    logic                  w_any_above;
    logic                  w_any_below;
    logic                  w_stopped;
    logic                  w_fc_multi;
    logic                  w_mu;
    logic                  w_md;
    logic                  w_door;
    logic                  w_fault;
    logic                  w_en;
    logic [6:0]            w_disp;

    function automatic logic [6:0] seg(input logic [FW-1:0] f);
        case (int'(f))
            0:       seg = 7'b0000110;
            1:       seg = 7'b1011011;
            2:       seg = 7'b1001111;
            3:       seg = 7'b1100110;
            4:       seg = 7'b1101101;
            5:       seg = 7'b1111101;
            6:       seg = 7'b0000111;
            default: seg = 7'b1111111;
        endcase
    endfunction

    assign w_up_idx   = r_cur_floor + FW'(1);
    assign w_dn_idx   = r_cur_floor - FW'(1);
    assign w_stopped  = (r_state == S_IDLE) || (r_state == S_DWELL);
    assign w_fc_multi = ($countones(fc) > 1);

    always_comb begin
        w_any_above = 1'b0;
        w_any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (r_req[i] && (FW'(i) > r_cur_floor)) w_any_above = 1'b1;
            if (r_req[i] && (FW'(i) < r_cur_floor)) w_any_below = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_last_dir  <= DIR_UP;
            r_cur_floor <= '0;
            r_req       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_last_dir  <= w_dir_nx;
            r_cur_floor <= w_floor_nx;
            r_req       <= w_req_nx;
            r_cnt       <= w_cnt_nx;
        end
    end

    // A call at the floor where the car is standing reopens the door instead of lighting a lamp.
    always_comb begin
        w_state_nx = r_state;
        w_dir_nx   = r_last_dir;
        w_floor_nx = r_cur_floor;
        w_cnt_nx   = r_cnt;
        w_req_nx   = r_req;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (call[i] && !(w_stopped && (FW'(i) == r_cur_floor))) w_req_nx[i] = 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (call[r_cur_floor]) begin
                    w_state_nx = S_DWELL;
                    w_cnt_nx   = '0;
                end else if (w_any_above && (r_last_dir == DIR_UP || !w_any_below)) begin
                    w_state_nx = S_MOVE_UP;
                    w_dir_nx   = DIR_UP;
                    w_cnt_nx   = '0;
                end else if (w_any_below) begin
                    w_state_nx = S_MOVE_DOWN;
                    w_dir_nx   = DIR_DOWN;
                    w_cnt_nx   = '0;
                end
            end
            S_MOVE_UP: begin
                if (fc[w_up_idx]) begin
                    w_floor_nx = w_up_idx;
                    w_cnt_nx   = '0;
                    if (r_req[w_up_idx] || w_up_idx == FLOOR_TOP) begin
                        w_state_nx         = S_DWELL;
                        w_req_nx[w_up_idx] = 1'b0;
                    end
                end else if (r_cnt == MOVE_LAST) begin
                    w_state_nx = S_FAULT;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_MOVE_DOWN: begin
                if (fc[w_dn_idx]) begin
                    w_floor_nx = w_dn_idx;
                    w_cnt_nx   = '0;
                    if (r_req[w_dn_idx] || w_dn_idx == '0) begin
                        w_state_nx         = S_DWELL;
                        w_req_nx[w_dn_idx] = 1'b0;
                    end
                end else if (r_cnt == MOVE_LAST) begin
                    w_state_nx = S_FAULT;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_DWELL: begin
                if (call[r_cur_floor]) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == DWELL_LAST) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            default: w_state_nx = S_FAULT;
        endcase
        if (w_fc_multi && r_state != S_FAULT) begin
            w_state_nx = S_FAULT;
            w_cnt_nx   = '0;
        end
        if (w_state_nx == S_FAULT) w_req_nx = '0;
    end

    // Outputs are decoded from the next state so the registered copies line up with it.
    always_comb begin
        w_mu    = (w_state_nx == S_MOVE_UP);
        w_md    = (w_state_nx == S_MOVE_DOWN);
        w_door  = (w_state_nx == S_DWELL);
        w_fault = (w_state_nx == S_FAULT);
        w_en    = !(w_mu || w_md);
        w_disp  = seg(w_floor_nx);
        if (w_fault) w_disp = SEG_ERR;
        else if (!w_en) w_disp = 7'b0000000;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            door_open  <= 1'b0;
            fault      <= 1'b0;
            enable     <= 1'b1;
            Display    <= 7'b0000110;
        end else begin
            motor_up   <= w_mu;
            motor_down <= w_md;
            door_open  <= w_door;
            fault      <= w_fault;
            enable     <= w_en;
            Display    <= w_disp;
        end
    end

    assign req_lamp = r_req;
endmodule

// File: tb/tb_multi_floor_lift.sv
// Directed scoreboard bench for multi_floor_lift with 4 floors, 8-cycle dwell, 64-cycle timeout.
module tb_multi_floor_lift;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] SE = 7'b1111001;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sbEntry_t;

    logic       clk;
    logic       reset;
    logic [3:0] call;
    logic [3:0] fc;
    logic       motor_up;
    logic       motor_down;
    logic [3:0] req_lamp;
    logic       door_open;
    logic       fault;
    logic       enable;
    logic [6:0] Display;

    sbEntry_t   sbQueue[$];
    int         checkCount = 0;
    int         passCount  = 0;

    multi_floor_lift #(.N_FLOORS(4), .DWELL_CYCLES(8), .MOVE_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .call(call), .fc(fc),
        .motor_up(motor_up), .motor_down(motor_down), .req_lamp(req_lamp),
        .door_open(door_open), .fault(fault), .enable(enable), .Display(Display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ev(input logic mu, input logic md, input logic door,
                                       input logic flt, input logic en,
                                       input logic [6:0] disp, input logic [3:0] req);
        return {mu, md, door, flt, en, disp, req};
    endfunction

    function automatic logic [15:0] idleExp(input logic [6:0] d, input logic [3:0] r);
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d, r);
    endfunction

    function automatic logic [15:0] dwellExp(input logic [6:0] d, input logic [3:0] r);
        return ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, d, r);
    endfunction

    function automatic logic [15:0] upExp(input logic [3:0] r);
        return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, r);
    endfunction

    function automatic logic [15:0] downExp(input logic [3:0] r);
        return ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000, r);
    endfunction

    function automatic logic [15:0] faultExp();
        return ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, SE, 4'b0000);
    endfunction

    task automatic checkOutput();
        sbEntry_t    e;
        logic [15:0] obs;
        obs = {motor_up, motor_down, door_open, fault, enable, Display, req_lamp};
        checkCount++;
        if (sbQueue.size() == 0) begin
            $error("[TB] FAIL scoreboard_empty observed=%h expected=entry", obs);
        end else begin
            e = sbQueue.pop_front();
            assert (obs === e.exp) passCount++;
            else $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
        end
        checkCount++;
        assert (!(motor_up === 1'b1 && motor_down === 1'b1)) passCount++;
        else $error("[TB] FAIL motor_exclusive observed=%b%b expected=not11", motor_up, motor_down);
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] c, input logic [3:0] f,
                                 input string tag, input logic [15:0] exp);
        sbEntry_t e;
        reset = rst;
        call  = c;
        fc    = f;
        e.tag = tag;
        e.exp = exp;
        sbQueue.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b0;
        call  = '0;
        fc    = '0;
        applyStimulus(1'b0, 4'b0000, 4'b0000, "reset_state", idleExp(S1, 4'b0000));

        // Floor 1 to floor 3 passing floor 2
        applyStimulus(1'b1, 4'b0100, 4'b0000, "a_latch", idleExp(S1, 4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "a_start_up", upExp(4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0010, "a_pass_f2", upExp(4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "a_still_up", upExp(4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0100, "a_arrive_f3", dwellExp(S3, 4'b0000));
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "a_dwell", dwellExp(S3, 4'b0000));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "a_dwell_end", idleExp(S3, 4'b0000));

        // Calls above and below with last direction up: top floor first, then reverse
        applyStimulus(1'b1, 4'b1001, 4'b0000, "b_latch", idleExp(S3, 4'b1001));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "b_prefer_up", upExp(4'b1001));
        applyStimulus(1'b1, 4'b0000, 4'b1000, "b_arrive_f4", dwellExp(S4, 4'b0001));
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "b_dwell_f4", dwellExp(S4, 4'b0001));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "b_idle_f4", idleExp(S4, 4'b0001));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "b_reverse", downExp(4'b0001));
        applyStimulus(1'b1, 4'b0000, 4'b0100, "b_pass_f3", downExp(4'b0001));
        applyStimulus(1'b1, 4'b0000, 4'b0010, "b_pass_f2", downExp(4'b0001));
        applyStimulus(1'b1, 4'b0000, 4'b0001, "b_arrive_f1", dwellExp(S1, 4'b0000));
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "b_dwell_f1", dwellExp(S1, 4'b0000));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "b_idle_f1", idleExp(S1, 4'b0000));

        // Call at the current floor opens the door and a repeat call restarts the dwell
        applyStimulus(1'b1, 4'b0001, 4'b0000, "c_here_call", dwellExp(S1, 4'b0000));
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "c_dwell", dwellExp(S1, 4'b0000));
        applyStimulus(1'b1, 4'b0001, 4'b0000, "c_restart", dwellExp(S1, 4'b0000));
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "c_dwell_restart", dwellExp(S1, 4'b0000));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "c_idle", idleExp(S1, 4'b0000));

        // Two limit switches at once while moving
        applyStimulus(1'b1, 4'b0010, 4'b0000, "d_latch", idleExp(S1, 4'b0010));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "d_start_up", upExp(4'b0010));
        applyStimulus(1'b1, 4'b0000, 4'b0011, "d_fc_multi", faultExp());
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 4'b1000, 4'b0000, "d_fault_hold", faultExp());
        applyStimulus(1'b0, 4'b0000, 4'b0000, "d_reset", idleExp(S1, 4'b0000));

        // No floor reached within the move timeout
        applyStimulus(1'b1, 4'b0100, 4'b0000, "e_latch", idleExp(S1, 4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "e_start_up", upExp(4'b0100));
        for (int k = 0; k < 63; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "e_moving", upExp(4'b0100));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "e_timeout", faultExp());
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 4'b0010, 4'b0100, "e_fault_hold", faultExp());
        applyStimulus(1'b0, 4'b0000, 4'b0000, "e_reset", idleExp(S1, 4'b0000));

        // Reset in the middle of a downward move with calls pending
        applyStimulus(1'b1, 4'b0010, 4'b0000, "f_latch", idleExp(S1, 4'b0010));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "f_start_up", upExp(4'b0010));
        applyStimulus(1'b1, 4'b0000, 4'b0010, "f_arrive_f2", dwellExp(S2, 4'b0000));
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 4'b0000, 4'b0000, "f_dwell_f2", dwellExp(S2, 4'b0000));
        applyStimulus(1'b1, 4'b0000, 4'b0000, "f_idle_f2", idleExp(S2, 4'b0000));
        applyStimulus(1'b1, 4'b0001, 4'b0000, "f_latch_down", idleExp(S2, 4'b0001));
        applyStimulus(1'b1, 4'b1000, 4'b0000, "f_start_down", downExp(4'b1001));
        applyStimulus(1'b0, 4'b0000, 4'b0000, "f_reset_mid_move", idleExp(S1, 4'b0000));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/multi_floor_lift.md
MULTI_FLOOR_LIFT -- requirements
Module: multi_floor_lift

Interface
REQ-001 SHALL have parameter N_FLOORS, default 4, number of floors; legal range 2..8.
REQ-002 SHALL have parameter DWELL_CYCLES, default 4000000, stop time in clk cycles (1 s at 4 MHz); legal minimum 1.
REQ-003 SHALL have parameter MOVE_TIMEOUT, default 40000000, maximum clk cycles allowed between two floors.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 SHALL have port call, input, N_FLOORS, per-floor call buttons, active-high level; bit 0 = floor 1.
REQ-007 SHALL have port fc, input, N_FLOORS, per-floor limit switches, active-high level.
REQ-008 SHALL have port motor_up, output, 1, motor runs up.
REQ-009 SHALL have port motor_down, output, 1, motor runs down.
REQ-010 SHALL have port req_lamp, output, N_FLOORS, latched pending calls.
REQ-011 SHALL have port door_open, output, 1, car stopped in dwell.
REQ-012 SHALL have port fault, output, 1, fault latched.
REQ-013 SHALL have port enable, output, 1, display enable.
REQ-014 SHALL have port Display, output, 7, segments gfedcba, common cathode.

Function
REQ-015 SHALL register all outputs; motor_up and motor_down SHALL never both be 1.
REQ-016 SHALL keep cur_floor (0..N_FLOORS-1) and last_dir (up/down).
REQ-017 SHALL use states IDLE, MOVE_UP, MOVE_DOWN, DWELL, FAULT.
REQ-018 SHALL set req[i] in the cycle after call[i]=1, unless the car is stopped (IDLE/DWELL) at floor i.
REQ-019 SHALL, on call[cur_floor]=1 in IDLE, go to DWELL; in DWELL, restart the dwell counter; req[cur_floor] SHALL stay 0.
REQ-020 SHALL, in IDLE, prefer last_dir: go MOVE_UP if any req above cur_floor and (last_dir=up or no req below); else MOVE_DOWN if any req below; else stay IDLE with motors off.
REQ-021 SHALL, in MOVE_UP, assert motor_up; on fc[cur_floor+1]=1 increment cur_floor; if req at the new floor, clear it, stop, and enter DWELL; otherwise continue.
REQ-022 SHALL treat MOVE_DOWN symmetrically with motor_down and fc[cur_floor-1].
REQ-023 SHALL, on reaching floor N_FLOORS-1 moving up or floor 0 moving down, enter DWELL regardless of req.
REQ-024 SHALL, in DWELL, hold motors off, assert door_open, count DWELL_CYCLES, then return to IDLE.
REQ-025 SHALL keep latching calls during DWELL and MOVE states.
REQ-026 SHALL enter FAULT when more than one fc bit is 1, or when a move lasts MOVE_TIMEOUT cycles without a new floor; the timer SHALL reset at each floor.
REQ-027 SHALL, in FAULT, hold motors off, assert fault, and clear req; only reset SHALL exit FAULT.
REQ-028 SHALL drive Display and enable=1 with the code for cur_floor+1 in IDLE/DWELL: 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111.
REQ-029 SHALL drive enable=0 and Display=0000000 in MOVE_UP/MOVE_DOWN; in FAULT SHALL drive Display=1111001 ("E") with enable=1.
REQ-030 SHALL size counters to hold the largest of DWELL_CYCLES and MOVE_TIMEOUT without wrap.

Reset
REQ-031 SHALL, when reset=0 at a clk edge, set state=IDLE, cur_floor=0, last_dir=up, req=0, counters=0, motors=0, door_open=0, fault=0, enable=1, Display=0000110.
REQ-032 SHALL let reset override every state, including mid-move, within one cycle.

Verification (N_FLOORS=4, DWELL_CYCLES=8, MOVE_TIMEOUT=64)
REQ-033 SHALL cover: pulse call[2] from floor 1 -> motor_up=1 and Display blank; pulse fc[1] -> still up; pulse fc[2] -> stop, door_open for 8 cycles, Display=1001111.
REQ-034 SHALL cover: at floor 2 moving up with req[3] and req[0] set -> serve floor 4 first, then reverse down to floor 1.
REQ-035 SHALL cover: call[0] while idle at floor 1 -> DWELL, req_lamp stays 0000, motors stay off.
REQ-036 SHALL cover: fc=0011 while moving, or 64 cycles without fc -> fault=1, motors 0, Display=1111001, held until reset.
REQ-037 SHALL cover: reset=0 mid-MOVE_DOWN with pending calls -> next cycle motors 0, req_lamp 0000, Display=0000110.
